// File: rtl/traffic_ctrl_nway.sv
// N-approach round-robin traffic-light controller: ALL_RED -> GREEN(d) -> YELLOW(d) -> ALL_RED.
// Optional macro SKIP_EMPTY_EN: the next green goes to the next approach with a waiting car.

module traffic_lamp_lane (
   input  logic       sel,
   input  logic [1:0] phase,
   output logic       r,
   output logic       g,
   output logic       y
);
   always_comb begin
      g = sel && (phase == 2'b01);
      y = sel && (phase == 2'b10);
      r = ~(g | y);
   end
endmodule

module traffic_ctrl_nway #(
   parameter int NUM_DIR      = 2,
   parameter int CNT_W        = 8,
   parameter int RED_TICKS    = 2,
   parameter int YELLOW_TICKS = 3,
   parameter int MIN_GREEN    = 4,
   parameter int MAX_GREEN    = 10,
   localparam int DIR_W       = $clog2(NUM_DIR)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               tick_en,
   input  logic               hold_red,
   input  logic [NUM_DIR-1:0] car_det,
   output logic [NUM_DIR-1:0] light_r,
   output logic [NUM_DIR-1:0] light_g,
   output logic [NUM_DIR-1:0] light_y,
   output logic [DIR_W-1:0]   active_dir,
   output logic [1:0]         phase,
   output logic [CNT_W-1:0]   phase_cnt
);
   typedef enum logic [1:0] {
      ALL_RED = 2'b00,
      GREEN   = 2'b01,
      YELLOW  = 2'b10
   } state_t;

   localparam logic [CNT_W-1:0] RED_T  = CNT_W'(RED_TICKS);
   localparam logic [CNT_W-1:0] YEL_T  = CNT_W'(YELLOW_TICKS);
   localparam logic [CNT_W-1:0] MIN_G  = CNT_W'(MIN_GREEN);
   localparam logic [CNT_W-1:0] MAX_G  = CNT_W'(MAX_GREEN);
   localparam logic [CNT_W-1:0] CNT_MX = '1;
   localparam logic [DIR_W-1:0] LAST_D = DIR_W'(NUM_DIR - 1);

   state_t             state, state_nxt;
   logic [DIR_W-1:0]   next_dir;
   logic [NUM_DIR-1:0] lane_sel;
   logic               other_car;

   // State, phase timer and served-approach registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ALL_RED;
         phase_cnt  <= '0;
         active_dir <= LAST_D;
      end else begin
         state <= state_nxt;
         if (state_nxt != state)
            phase_cnt <= '0;
         else if (tick_en && (phase_cnt != CNT_MX))
            phase_cnt <= phase_cnt + 1'b1;
         if ((state == ALL_RED) && (state_nxt == GREEN))
            active_dir <= next_dir;
      end
   end

`ifdef SKIP_EMPTY_EN
   logic             found;
   logic [DIR_W-1:0] cand;
`endif

   // Successor approach; the scan visits the current index last
   always_comb begin
      next_dir = (active_dir == LAST_D) ? '0 : active_dir + 1'b1;
`ifdef SKIP_EMPTY_EN
      found = 1'b0;
      cand  = active_dir;
      for (int k = 0; k < NUM_DIR; k++) begin
         cand = (cand == LAST_D) ? '0 : cand + 1'b1;
         if (!found && car_det[cand]) begin
            found    = 1'b1;
            next_dir = cand;
         end
      end
`endif
   end

   always_comb begin
      other_car = |(car_det & ~lane_sel);
      state_nxt = state;
      case (state)
         ALL_RED: if (!hold_red && (phase_cnt >= RED_T)) state_nxt = GREEN;
         GREEN:   if ((phase_cnt >= MAX_G) || ((phase_cnt >= MIN_G) && other_car))
                     state_nxt = YELLOW;
         YELLOW:  if (phase_cnt >= YEL_T) state_nxt = ALL_RED;
         default: state_nxt = ALL_RED;
      endcase
   end

   always_comb begin
      phase = state;
      for (int i = 0; i < NUM_DIR; i++)
         lane_sel[i] = (active_dir == DIR_W'(i));
   end

   for (genvar i = 0; i < NUM_DIR; i++) begin : g_lane
      traffic_lamp_lane u_lane (
         .sel   (lane_sel[i]),
         .phase (phase),
         .r     (light_r[i]),
         .g     (light_g[i]),
         .y     (light_y[i])
      );
   end
endmodule

// File: tb/tb_traffic_ctrl_nway.sv
// Directed bench for traffic_ctrl_nway: a 2-way default instance and a 4-way instance.
module tb_traffic_ctrl_nway;
   logic       clk = 1'b0;
   logic       rst, tick_en, hold_red;
   logic [1:0] car_det, light_r, light_g, light_y, phase;
   logic [0:0] active_dir;
   logic [7:0] phase_cnt;
   logic [3:0] car4, r4, g4, y4;
   logic [1:0] dir4, phase4;
   logic [7:0] cnt4;
   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   traffic_ctrl_nway dut (
      .clk(clk), .rst(rst), .tick_en(tick_en), .hold_red(hold_red), .car_det(car_det),
      .light_r(light_r), .light_g(light_g), .light_y(light_y),
      .active_dir(active_dir), .phase(phase), .phase_cnt(phase_cnt));

   traffic_ctrl_nway #(.NUM_DIR(4)) dut4 (
      .clk(clk), .rst(rst), .tick_en(1'b1), .hold_red(1'b0), .car_det(car4),
      .light_r(r4), .light_g(g4), .light_y(y4),
      .active_dir(dir4), .phase(phase4), .phase_cnt(cnt4));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_a(input string tag, input logic [1:0] ph, input logic [7:0] cnt,
                        input logic d, input logic [1:0] r, input logic [1:0] g,
                        input logic [1:0] y);
      chk({tag, ".phase"}, 32'(phase), 32'(ph));
      chk({tag, ".cnt"}, 32'(phase_cnt), 32'(cnt));
      chk({tag, ".dir"}, 32'(active_dir), 32'(d));
      chk({tag, ".r"}, 32'(light_r), 32'(r));
      chk({tag, ".g"}, 32'(light_g), 32'(g));
      chk({tag, ".y"}, 32'(light_y), 32'(y));
      chk({tag, ".one_lamp"}, 32'((light_r & light_g) | (light_r & light_y) | (light_g & light_y)), 0);
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; tick_en = 1'b1; hold_red = 1'b0; car_det = 2'b00; car4 = 4'b0000;
      step(2);
      rst = 1'b0;
      chk_a("reset", 2'b00, 8'd0, 1'b1, 2'b11, 2'b00, 2'b00);
      chk("reset4.dir", 32'(dir4), 32'd3);
      chk("reset4.r", 32'(r4), 32'hf);
      step(2);
      chk_a("red2", 2'b00, 8'd2, 1'b1, 2'b11, 2'b00, 2'b00);
      step(1);
      chk_a("green0", 2'b01, 8'd0, 1'b0, 2'b10, 2'b01, 2'b00);
      chk("green0_4.g", 32'(g4), 32'h1);
      car4 = 4'b1000;
      step(4);
      chk("g4_min.phase", 32'(phase4), 32'd1);
      chk("g4_min.cnt", 32'(cnt4), 32'd4);
      step(1);
      chk("g4_exit.phase", 32'(phase4), 32'd2);
      chk("g4_exit.y", 32'(y4), 32'h1);
      step(5);
      chk_a("green_max", 2'b01, 8'd10, 1'b0, 2'b10, 2'b01, 2'b00);
      chk("g4_red.phase", 32'(phase4), 32'd0);
      step(1);
      chk_a("yellow0", 2'b10, 8'd0, 1'b0, 2'b10, 2'b00, 2'b01);
      step(1);
`ifdef SKIP_EMPTY_EN
      chk("g4_next.g", 32'(g4), 32'h8);
      chk("g4_next.dir", 32'(dir4), 32'd3);
`else
      chk("g4_next.g", 32'(g4), 32'h2);
      chk("g4_next.dir", 32'(dir4), 32'd1);
`endif
      step(2);
      chk_a("yellow_end", 2'b10, 8'd3, 1'b0, 2'b10, 2'b00, 2'b01);
      step(1);
      chk_a("red_after_y", 2'b00, 8'd0, 1'b0, 2'b11, 2'b00, 2'b00);
      step(2);
      chk("red_end.phase", 32'(phase), 32'd0);
      step(1);
      chk_a("green1", 2'b01, 8'd0, 1'b1, 2'b01, 2'b10, 2'b00);
      car_det = 2'b10;
      step(5);
      chk_a("own_car", 2'b01, 8'd5, 1'b1, 2'b01, 2'b10, 2'b00);
      car_det = 2'b01;
      step(1);
      chk_a("early_y", 2'b10, 8'd0, 1'b1, 2'b01, 2'b00, 2'b10);
      car_det = 2'b00;
      step(1);
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      chk_a("rst_y", 2'b00, 8'd0, 1'b1, 2'b11, 2'b00, 2'b00);
      hold_red = 1'b1;
      step(20);
      chk_a("hold20", 2'b00, 8'd20, 1'b1, 2'b11, 2'b00, 2'b00);
      step(240);
      chk("hold_sat.cnt", 32'(phase_cnt), 32'd255);
      step(1);
      chk_a("hold_sat2", 2'b00, 8'd255, 1'b1, 2'b11, 2'b00, 2'b00);
      hold_red = 1'b0;
      step(1);
      chk_a("hold_rel", 2'b01, 8'd0, 1'b0, 2'b10, 2'b01, 2'b00);
      step(2);
      tick_en = 1'b0;
      car_det = 2'b11;
      step(50);
      chk_a("frozen", 2'b01, 8'd2, 1'b0, 2'b10, 2'b01, 2'b00);
      tick_en = 1'b1;
      step(2);
      chk_a("thaw", 2'b01, 8'd4, 1'b0, 2'b10, 2'b01, 2'b00);
      step(1);
      chk_a("exit4", 2'b10, 8'd0, 1'b0, 2'b10, 2'b00, 2'b01);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
